// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, opcodes and sizing for the MUL/DIV sequencer
package alu_seq_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;
    localparam int ITER = 8;
    localparam int ADD_W = 9;
endpackage

// File: rtl/parallel_adder.sv
// parallel_adder: W-bit ripple-carry adder built from full-adder cells
module parallel_adder #(
    parameter int W = 9
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);
    logic [W:0] c;
    assign c[0] = cin;
    assign cout = c[W];
    for (genvar i = 0; i < W; i++) begin : g_fa
        assign sum[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1]   = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
endmodule

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: 8-iteration radix-2 Booth signed multiply / restoring unsigned divide
// sharing one 9-bit ripple adder; start/busy/done handshake with held results.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_by_zero
);
    state_t             state;
    logic [2:0]         cnt;
    logic               op_r;
    logic [ADD_W-1:0]   acc, m_r;
    logic [WIDTH-1:0]   q;
    logic               q_1;
    logic [ADD_W-1:0]   r_sh, x, y, sum, acc_n;
    logic [WIDTH-1:0]   q_n;
    logic [1:0]         booth;
    logic               cin, cout_unused, accept, last;

    // acc holds Booth A for MUL and partial remainder R for DIV; m_r holds M or D
    always_comb begin
        r_sh   = {acc[ADD_W-2:0], q[WIDTH-1]};
        booth  = {q[0], q_1};
        x      = op_r == OP_DIV ? r_sh : acc;
        y      = op_r == OP_DIV ? ~m_r : booth == 2'b01 ? m_r : booth == 2'b10 ? ~m_r : '0;
        cin    = op_r == OP_DIV || booth == 2'b10;
        acc_n  = op_r == OP_DIV ? (sum[ADD_W-1] ? r_sh : sum) : {sum[ADD_W-1], sum[ADD_W-1:1]};
        q_n    = op_r == OP_DIV ? {q[WIDTH-2:0], ~sum[ADD_W-1]} : {sum[0], q[WIDTH-1:1]};
        accept = start && state != CALC;
        last   = cnt == 3'(ITER - 1);
    end

    parallel_adder #(.W(ADD_W)) u_add (
        .x   (x),
        .y   (y),
        .cin (cin),
        .sum (sum),
        .cout(cout_unused)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_r        <= OP_MUL;
            acc         <= '0;
            m_r         <= '0;
            q           <= '0;
            q_1         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result_hi   <= '0;
            result_lo   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            state       <= CALC;
            cnt         <= '0;
            op_r        <= op;
            acc         <= '0;
            m_r         <= op == OP_DIV ? {1'b0, b} : {a[WIDTH-1], a};
            q           <= op == OP_DIV ? a : b;
            q_1         <= 1'b0;
            busy        <= 1'b1;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (state == CALC) begin
            acc <= acc_n;
            q   <= q_n;
            q_1 <= q[0];
            cnt <= cnt + 3'd1;
            if (last) begin
                state       <= DONE;
                busy        <= 1'b0;
                done        <= 1'b1;
                result_hi   <= acc_n[WIDTH-1:0];
                result_lo   <= q_n;
                div_by_zero <= op_r == OP_DIV && m_r == '0;
            end
        end else begin
            state <= IDLE;
            done  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_seq_muldiv.sv
// tb_alu_seq_muldiv: directed vectors pushed to a scoreboard; a monitor checks every done
// pulse for result, div_by_zero, latency and busy length.
module tb_alu_seq_muldiv;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       op = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] result_hi, result_lo;

    typedef struct {
        logic [16:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   busy_len = 0;

    alu_seq_muldiv #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .op         (op),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .result_hi  (result_hi),
        .result_lo  (result_lo),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // caller must be at a negedge; the following posedge samples start
    task automatic issue(input logic o, input logic [7:0] ai, input logic [7:0] bi,
                         input logic [16:0] res, input string name);
        start = 1'b1;
        op    = o;
        a     = ai;
        b     = bi;
        sb.push_back('{res, cyc + 9, name});
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (sb.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    always @(negedge clk) begin
        if (rst) busy_len = 0;
        else if (busy) busy_len++;
        if (!rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.name, "_result"}, {15'd0, div_by_zero, result_hi, result_lo}, {15'd0, e.res});
                chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                chk({e.name, "_busy_len"}, 32'(busy_len), 32'd8);
            end
            busy_len = 0;
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_outputs", {27'd0, busy, done, div_by_zero, |result_hi, |result_lo}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 8'h07, 8'hFD, {1'b0, 16'hFFEB}, "mul_7_m3");
        wait_idle();
        issue(1'b0, 8'h80, 8'h80, {1'b0, 16'h4000}, "mul_m128_m128");
        wait_idle();
        issue(1'b0, 8'h80, 8'h01, {1'b0, 16'hFF80}, "mul_m128_1");
        wait_idle();
        issue(1'b1, 8'd200, 8'd7, {1'b0, 8'd4, 8'd28}, "div_200_7");
        wait_idle();
        issue(1'b1, 8'h55, 8'h00, {1'b1, 8'h55, 8'hFF}, "div_by_zero");
        wait_idle();
        start = 1'b1; op = 1'b0; a = 8'd3; b = 8'd5;
        sb.push_back('{{1'b0, 16'h000F}, cyc + 9, "mul_3_5"});
        @(negedge clk);
        start = 1'b0;
        chk("dbz_cleared_on_start", {30'd0, div_by_zero, busy}, 32'd1);
        wait_idle();
        issue(1'b0, 8'h0A, 8'hFE, {1'b0, 16'hFFEC}, "mul_ignore_start");
        repeat (2) @(negedge clk);
        start = 1'b1; op = 1'b1; a = 8'd1; b = 8'd1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        issue(1'b0, 8'h07, 8'hFD, {1'b0, 16'hFFEB}, "b2b_first");
        wait_done();
        issue(1'b1, 8'd100, 8'd7, {1'b0, 8'd2, 8'd14}, "b2b_second");
        wait_idle();
        issue(1'b0, 8'h05, 8'h05, {1'b0, 16'h0019}, "mul_aborted");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("abort_outputs", {27'd0, busy, done, div_by_zero, |result_hi, |result_lo}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_no_done", {31'd0, done}, 32'd0);
        issue(1'b1, 8'd100, 8'd10, {1'b0, 8'd0, 8'd10}, "div_100_10");
        wait_idle();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
